// File: rtl/rect_scanner.sv
// Raster scanner over a programmable, screen-clipped rectangle with a valid/ready
// coordinate output. Optional loop mode re-scans the region back to back.
module rect_scanner #(
  parameter int unsigned XW    = 8,
  parameter int unsigned YW    = 7,
  parameter int unsigned X_MAX = 160,
  parameter int unsigned Y_MAX = 120
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [XW-1:0] x_origin,
  input  logic [YW-1:0] y_origin,
  input  logic [XW:0]   width,
  input  logic [YW:0]   height,
  input  logic          loop,
  input  logic          ready,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          plot,
  output logic          busy,
  output logic          done
);

  localparam int unsigned XEW = XW + 1;
  localparam int unsigned YEW = YW + 1;
  localparam int unsigned XSW = XW + 2;
  localparam int unsigned YSW = YW + 2;

  localparam logic [XW:0] X_LIM = XEW'(X_MAX);
  localparam logic [YW:0] Y_LIM = YEW'(Y_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [XW-1:0] x0, x0_d, x_d;
  logic [YW-1:0] y0, y0_d, y_d;
  logic [XW:0]   x_end, x_end_d;
  logic [YW:0]   y_end, y_end_d;
  logic          plot_d, busy_d, done_d;

  logic [XW+1:0] x_sum;
  logic [YW+1:0] y_sum;
  logic [XW:0]   x_clip;
  logic [YW:0]   y_clip;
  logic          empty;
  logic [XW:0]   x_inc;
  logic [YW:0]   y_inc;
  logic          accept;

  // Exclusive end coordinates, summed one bit wider so origin+size cannot wrap
  assign x_sum  = XSW'(x_origin) + XSW'(width);
  assign y_sum  = YSW'(y_origin) + YSW'(height);
  assign x_clip = (x_sum > XSW'(X_LIM)) ? X_LIM : x_sum[XW:0];
  assign y_clip = (y_sum > YSW'(Y_LIM)) ? Y_LIM : y_sum[YW:0];
  assign empty  = (width == '0) || (height == '0) ||
                  (XEW'(x_origin) >= X_LIM) || (YEW'(y_origin) >= Y_LIM);

  assign x_inc  = XEW'(x) + XEW'(1);
  assign y_inc  = YEW'(y) + YEW'(1);
  assign accept = plot & ready;

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      x0    <= '0;
      y0    <= '0;
      x_end <= '0;
      y_end <= '0;
      plot  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      x     <= x_d;
      y     <= y_d;
      x0    <= x0_d;
      y0    <= y0_d;
      x_end <= x_end_d;
      y_end <= y_end_d;
      plot  <= plot_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  // Next state; plot/busy/done are computed for the cycle after the edge
  always_comb begin
    state_d = state;
    x_d     = x;
    y_d     = y;
    x0_d    = x0;
    y0_d    = y0;
    x_end_d = x_end;
    y_end_d = y_end;
    plot_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          x0_d    = x_origin;
          y0_d    = y_origin;
          x_end_d = x_clip;
          y_end_d = y_clip;
          busy_d  = 1'b1;
          if (empty) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = SCAN;
            x_d     = x_origin;
            y_d     = y_origin;
            plot_d  = 1'b1;
          end
        end
      end

      SCAN: begin
        busy_d = 1'b1;
        plot_d = 1'b1;
        if (accept) begin
          if (x_inc < x_end) begin
            x_d = x_inc[XW-1:0];
          end else if (y_inc < y_end) begin
            x_d = x0;
            y_d = y_inc[YW-1:0];
          end else begin
            done_d = 1'b1;
            if (loop) begin
              x_d = x0;
              y_d = y0;
            end else begin
              state_d = DONE;
              plot_d  = 1'b0;
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rect_scanner.sv
// Scoreboard bench for rect_scanner: expected coordinates are queued when a scan is
// started and popped on each accepted beat; done is checked against the last beat.
module tb_rect_scanner;

  localparam int XW    = 8;
  localparam int YW    = 7;
  localparam int X_MAX = 160;
  localparam int Y_MAX = 120;

  logic          clock;
  logic          reset;
  logic          start;
  logic [XW-1:0] x_origin;
  logic [YW-1:0] y_origin;
  logic [XW:0]   width;
  logic [YW:0]   height;
  logic          loop;
  logic          ready;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          plot;
  logic          busy;
  logic          done;

  rect_scanner #(.XW(XW), .YW(YW), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .x_origin (x_origin),
    .y_origin (y_origin),
    .width    (width),
    .height   (height),
    .loop     (loop),
    .ready    (ready),
    .x        (x),
    .y        (y),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    int x;
    int y;
    bit last;
  } beat_t;

  beat_t q[$];

  int total, bad;
  int done_cnt, beats, cyc, first_cyc, last_cyc, max_x;
  int hx, hy;
  bit mon_en, prev_last, held_valid, rmode;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input int x0, input int y0, input int w, input int h);
    int xe, ye;
    beat_t b;
    xe = (x0 + w > X_MAX) ? X_MAX : x0 + w;
    ye = (y0 + h > Y_MAX) ? Y_MAX : y0 + h;
    for (int yy = y0; yy < ye; yy++) begin
      for (int xx = x0; xx < xe; xx++) begin
        b.x    = xx;
        b.y    = yy;
        b.last = (xx == xe - 1) && (yy == ye - 1);
        q.push_back(b);
      end
    end
  endtask

  task automatic clear_stats();
    done_cnt  = 0;
    beats     = 0;
    first_cyc = -1;
    last_cyc  = -1;
    max_x     = 0;
  endtask

  task automatic start_scan(input int x0, input int y0, input int w, input int h, input int hold);
    @(posedge clock);
    #1;
    x_origin = XW'(x0);
    y_origin = YW'(y0);
    width    = (XW+1)'(w);
    height   = (YW+1)'(h);
    start    = 1'b1;
    repeat (hold) @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("idle_in_budget", int'(n < budget), 1);
    check("sb_drained", q.size(), 0);
  endtask

  // Downstream ready: tied high or random, changed just after each rising edge
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor on the falling edge: accepted beats, stall stability, done timing
  always @(negedge clock) begin
    cyc++;
    if (mon_en) begin
      beat_t e;
      check("done_after_last", int'(done), int'(prev_last));
      prev_last = 1'b0;
      if (done) done_cnt++;
      if (held_valid && plot) begin
        check("stall_x", int'(x), hx);
        check("stall_y", int'(y), hy);
      end
      held_valid = 1'b0;
      if (plot && ready) begin
        check("sb_avail", int'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("x", int'(x), e.x);
          check("y", int'(y), e.y);
          prev_last = e.last;
          beats++;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          if (int'(x) > max_x) max_x = int'(x);
        end
      end else if (plot) begin
        held_valid = 1'b1;
        hx = int'(x);
        hy = int'(y);
      end
    end
  end

  int ecase[3][4] = '{'{5, 5, 0, 4}, '{200, 5, 4, 4}, '{5, 5, 4, 0}};

  initial begin
    total = 0; bad = 0; cyc = 0;
    mon_en = 1'b0; prev_last = 1'b0; held_valid = 1'b0; rmode = 1'b0;
    start = 1'b0; loop = 1'b0;
    x_origin = '0; y_origin = '0; width = '0; height = '0;
    clear_stats();
    reset = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // full screen, ready tied high
    clear_stats();
    push_frame(0, 0, 160, 120);
    start_scan(0, 0, 160, 120, 1);
    wait_idle(20000);
    check("full_beats", beats, 19200);
    check("full_done", done_cnt, 1);
    check("full_span", last_cyc - first_cyc + 1, 19200);
    check("full_max_x", max_x, 159);

    // clipped at the bottom-right corner
    clear_stats();
    push_frame(150, 115, 20, 10);
    start_scan(150, 115, 20, 10, 1);
    wait_idle(200);
    check("clip_beats", beats, 50);
    check("clip_done", done_cnt, 1);

    // random backpressure
    rmode = 1'b1;
    clear_stats();
    push_frame(5, 5, 3, 2);
    start_scan(5, 5, 3, 2, 1);
    wait_idle(500);
    rmode = 1'b0;
    check("bp_beats", beats, 6);
    check("bp_done", done_cnt, 1);

    // start held through last-pixel accept and DONE must not restart
    clear_stats();
    push_frame(10, 10, 1, 1);
    start_scan(10, 10, 1, 1, 3);
    wait_idle(50);
    repeat (3) @(negedge clock);
    check("hold_beats", beats, 1);
    check("hold_done", done_cnt, 1);
    check("hold_busy", int'(busy), 0);

    // empty regions: one DONE cycle, no pixel
    mon_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_scan(ecase[i][0], ecase[i][1], ecase[i][2], ecase[i][3], 1);
      @(negedge clock);
      check("empty_plot1", int'(plot), 0);
      check("empty_busy1", int'(busy), 1);
      check("empty_done1", int'(done), 1);
      @(negedge clock);
      check("empty_plot2", int'(plot), 0);
      check("empty_busy2", int'(busy), 0);
      check("empty_done2", int'(done), 0);
    end
    mon_en = 1'b1;

    // loop mode: three 2x2 frames back to back, loop dropped during the third
    clear_stats();
    loop = 1'b1;
    for (int f = 0; f < 3; f++) push_frame(0, 0, 2, 2);
    start_scan(0, 0, 2, 2, 1);
    repeat (9) @(posedge clock);
    #1;
    loop = 1'b0;
    wait_idle(100);
    check("loop_beats", beats, 12);
    check("loop_done", done_cnt, 3);
    check("loop_span", last_cyc - first_cyc + 1, 12);

    // asynchronous reset in the middle of a scan, then a fresh scan
    clear_stats();
    push_frame(0, 0, 160, 120);
    start_scan(0, 0, 160, 120, 1);
    repeat (37) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("arst_x", int'(x), 0);
    check("arst_y", int'(y), 0);
    check("arst_plot", int'(plot), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    q.delete();
    prev_last = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    clear_stats();
    push_frame(3, 4, 4, 3);
    start_scan(3, 4, 4, 3, 1);
    wait_idle(100);
    check("post_rst_beats", beats, 12);
    check("post_rst_done", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
